// File: rtl/reflet_float_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : reflet_float_program_loader
// Purpose  : Streams a length-prefixed program (16-bit words, low byte first)
//            into a Reflet float CU instruction RAM. Define
//            REFLET_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module reflet_float_program_loader #(
    parameter int max_instructions = 128,
    parameter int float_size       = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        writing_instructions,
    output logic [15:0] instruction_feed,
    output logic        instruction_write_en,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LEN_LO  = 3'd1;
    localparam logic [2:0] c_ST_LEN_HI  = 3'd2;
    localparam logic [2:0] c_ST_DATA_LO = 3'd3;
    localparam logic [2:0] c_ST_DATA_HI = 3'd4;
    localparam logic [2:0] c_ST_WRITE   = 3'd5;
    localparam logic [2:0] c_ST_FINISH  = 3'd7;
`ifdef REFLET_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_ST_CHK     = 3'd6;
    localparam logic [2:0] c_ST_AFTER   = c_ST_CHK;
`else
    localparam logic [2:0] c_ST_AFTER   = c_ST_FINISH;
`endif

    // The length limit is compared at the CU word width.
    typedef logic [float_size-1:0] t_limit;
    localparam t_limit c_MAX = t_limit'(max_instructions);

    logic [2:0]  r_state;
    logic [7:0]  r_len_lo;
    logic [15:0] r_n;
    logic [15:0] r_cnt;
    logic [7:0]  r_lo;
    logic [15:0] r_feed;
    logic        r_error;
`ifdef REFLET_LOADER_CHECKSUM_EN
    logic [7:0]  r_chk;
`endif

    logic        w_ready;
    logic        w_accept;
    logic [15:0] w_len;
    logic [15:0] w_cnt_next;
    logic        w_too_long;

    always_comb begin
        w_ready = (r_state == c_ST_LEN_LO)  || (r_state == c_ST_LEN_HI) ||
                  (r_state == c_ST_DATA_LO) || (r_state == c_ST_DATA_HI);
`ifdef REFLET_LOADER_CHECKSUM_EN
        if (r_state == c_ST_CHK) begin
            w_ready = 1'b1;
        end
`endif
    end

    assign w_accept   = byte_valid && w_ready;
    assign w_len      = {byte_in, r_len_lo};
    assign w_cnt_next = r_cnt + 16'd1;
    assign w_too_long = t_limit'(w_len) > c_MAX;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_len_lo <= 8'd0;
            r_n      <= 16'd0;
            r_cnt    <= 16'd0;
            r_lo     <= 8'd0;
            r_feed   <= 16'd0;
            r_error  <= 1'b0;
`ifdef REFLET_LOADER_CHECKSUM_EN
            r_chk    <= 8'd0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state <= c_ST_LEN_LO;
                        r_error <= 1'b0;
                        r_cnt   <= 16'd0;
`ifdef REFLET_LOADER_CHECKSUM_EN
                        r_chk   <= 8'd0;
`endif
                    end
                end
                c_ST_LEN_LO: begin
                    if (w_accept) begin
                        r_len_lo <= byte_in;
                        r_state  <= c_ST_LEN_HI;
                    end
                end
                c_ST_LEN_HI: begin
                    if (w_accept) begin
                        r_n <= w_len;
                        if (w_len == 16'd0) begin
                            r_state <= c_ST_AFTER;
                        end else if (w_too_long) begin
                            r_error <= 1'b1;
                            r_state <= c_ST_FINISH;
                        end else begin
                            r_state <= c_ST_DATA_LO;
                        end
                    end
                end
                c_ST_DATA_LO: begin
                    if (w_accept) begin
                        r_lo    <= byte_in;
                        r_state <= c_ST_DATA_HI;
`ifdef REFLET_LOADER_CHECKSUM_EN
                        r_chk   <= r_chk ^ byte_in;
`endif
                    end
                end
                c_ST_DATA_HI: begin
                    // Feed is loaded here so it is stable for the whole WRITE cycle.
                    if (w_accept) begin
                        r_feed  <= {byte_in, r_lo};
                        r_state <= c_ST_WRITE;
`ifdef REFLET_LOADER_CHECKSUM_EN
                        r_chk   <= r_chk ^ byte_in;
`endif
                    end
                end
                c_ST_WRITE: begin
                    r_cnt   <= w_cnt_next;
                    r_state <= (w_cnt_next == r_n) ? c_ST_AFTER : c_ST_DATA_LO;
                end
`ifdef REFLET_LOADER_CHECKSUM_EN
                c_ST_CHK: begin
                    if (w_accept) begin
                        if (byte_in != r_chk) begin
                            r_error <= 1'b1;
                        end
                        r_state <= c_ST_FINISH;
                    end
                end
`endif
                c_ST_FINISH: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign byte_ready           = w_ready;
    assign writing_instructions = (r_state != c_ST_IDLE) && (r_state != c_ST_FINISH);
    assign instruction_feed     = r_feed;
    assign instruction_write_en = (r_state == c_ST_WRITE) && !r_error;
    assign busy                 = (r_state != c_ST_IDLE);
    assign done                 = (r_state == c_ST_FINISH);
    assign error                = r_error;

endmodule
`default_nettype wire

// File: doc/reflet_float_program_loader.md
REFLET_FLOAT_PROGRAM_LOADER -- requirements
Module: reflet_float_program_loader

Interface
REQ-001 Parameter max_instructions, default 128: instruction RAM capacity in 16-bit instructions.
REQ-002 Parameter float_size, default 32: word width of the attached CU; used only for the width of the internal count limit check.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  pulse; begins a load when the loader is idle.
REQ-006 byte_in  input  8  incoming program byte.
REQ-007 byte_valid  input  1  byte_in is valid.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle; transfer occurs when byte_valid && byte_ready.
REQ-009 writing_instructions  output  1  drives the CU instruction-write mode; holds the CU write address at 0 while low.
REQ-010 instruction_feed  output  16  instruction word to the CU.
REQ-011 instruction_write_en  output  1  one-cycle write strobe to the CU.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  one-cycle pulse at load end.
REQ-014 error  output  1  sticky load failure, cleared by the next accepted start.

Function
REQ-015 Stream format SHALL be: count N (16-bit, low byte first), then N instructions of 2 bytes each (low byte first), then the checksum byte when enabled (REQ-030).
REQ-016 States SHALL be IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHK, FINISH.
REQ-017 IDLE: start=1 SHALL go to LEN_LO and clear error and the instruction counter; start SHALL be ignored in every other state.
REQ-018 byte_ready SHALL be 1 exactly in LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHK; each state SHALL advance only on an accepted byte, and waits indefinitely otherwise.
REQ-019 LEN_HI on accept: N=0 SHALL go to FINISH (via CHK when enabled); N>max_instructions SHALL set error and go to FINISH without any write; otherwise SHALL go to DATA_LO.
REQ-020 DATA_HI on accept SHALL go to WRITE; WRITE SHALL last exactly one cycle with instruction_write_en=1 and instruction_feed={high byte, low byte}.
REQ-021 After WRITE the counter SHALL increment; if counter equals N, next state SHALL be CHK (enabled) or FINISH, else DATA_LO.
REQ-022 writing_instructions SHALL be 1 from the LEN_LO state through the last WRITE/CHK cycle and 0 in IDLE and FINISH, so the CU address starts at 0 and advances by 2 per strobe.
REQ-023 instruction_write_en SHALL be 1 only in WRITE; never when error is set.
REQ-024 FINISH SHALL last one cycle, assert done, and return to IDLE; busy SHALL be 1 in all states except IDLE.
REQ-025 Minimum throughput: 3 cycles per instruction with byte_valid held high.
REQ-026 instruction_feed SHALL hold its last written value outside WRITE.

Reset
REQ-027 On reset=1 at a clock edge: state IDLE; byte_ready, writing_instructions, instruction_write_en, busy, done, error = 0; instruction_feed, counter, N = 0.
REQ-028 Reset mid-load SHALL abort immediately with no further write strobes; partially written instructions remain in CU RAM.
REQ-029 reset has priority over start and byte_valid in the same cycle.

Configuration
REQ-030 Macro REFLET_LOADER_CHECKSUM_EN defined: CHK state accepts one byte that SHALL equal the XOR of all data bytes (length bytes excluded, 0x00 for N=0); mismatch sets error; then FINISH.
REQ-031 Macro undefined: CHK state SHALL not exist, no checksum byte is consumed, and error is raised only by REQ-019.

Verification
REQ-032 start, stream 02 00 34 12 78 56 (+ chk 0x08 if enabled) -> two strobes with feed 0x1234 then 0x5678, CU addresses 0 and 2, done pulse, error=0.
REQ-033 start, stream 00 00 (+ 00) -> no strobe, done pulse one cycle after last byte, error=0.
REQ-034 start, count 81 00 (129) with max_instructions=128 -> error=1, done pulse, zero strobes, byte_ready low afterwards.
REQ-035 byte_valid toggled 1/0 each cycle during 3-instruction load -> exactly 3 strobes, correct order, no byte lost or duplicated.
REQ-036 reset asserted after first strobe of a 4-instruction load -> all outputs 0 next cycle, no further strobes; new start loads from CU address 0.
REQ-037 Checksum enabled, stream 01 00 AA 55 00 (expected FF) -> one strobe 0x55AA, error=1, done pulse.
